// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings, request record and legality helper for the load/store sequencer.
package lsu_ctrl_pkg;

  // funct3 encodings (loads use all five, stores use the first three)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // A request is legal when funct3 exists for its direction and the address is naturally aligned.
  function automatic logic lsu_legal(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic ok_f3;
    logic ok_al;
    if (we) ok_f3 = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    ok_f3 = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    case (f3[1:0])
      2'b00:   ok_al = 1'b1;
      2'b01:   ok_al = ~a[0];
      2'b10:   ok_al = (a == 2'b00);
      default: ok_al = 1'b0;
    endcase
    return ok_f3 & ok_al;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core request/response and data-bus signals of the load/store sequencer.
interface lsu_ctrl_if;
  logic        core_valid;
  logic        core_ready;
  logic        core_we;
  logic [2:0]  core_funct3;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        bus_req;
  logic        bus_gnt;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  // the sequencer itself: bus master toward memory, responder toward the core
  modport master (
    input  core_valid, core_we, core_funct3, core_addr, core_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata, bus_err,
    output core_ready, rsp_valid, rsp_rdata, rsp_err,
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  // the environment: execute stage plus data bus
  modport slave (
    output core_valid, core_we, core_funct3, core_addr, core_wdata,
    output bus_gnt, bus_rvalid, bus_rdata, bus_err,
    input  core_ready, rsp_valid, rsp_rdata, rsp_err,
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/lsu_ctrl_ext.sv
// Load-data extension: picks byte/half/word from an already lane-shifted word and extends it.
module lsu_ctrl_ext
  import lsu_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  output logic [31:0] ext
);

  // select width and sign/zero extend
  always_comb begin
    ext = word;
    case (funct3)
      F3_B:    ext = {{24{word[7]}}, word[7:0]};
      F3_H:    ext = {{16{word[15]}}, word[15:0]};
      F3_BU:   ext = {24'h0, word[7:0]};
      F3_HU:   ext = {16'h0, word[15:0]};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the RV32 execute stage and a single-port data bus.
//
//  state   | meaning
//  IDLE    | ready for a request; latches it on valid&ready
//  REQ     | bus_req held with stable addr/we/be/wdata until bus_gnt
//  WAIT    | granted, waiting for bus_rvalid (data or write ack)
//  RESP    | result settled; rsp_valid is registered out on leaving
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic        clk,
  input logic        rst_n,
  lsu_ctrl_if.master lsu
);

  localparam int unsigned    TW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMR_LOAD = TW'(TIMEOUT_CYCLES);

  logic [1:0]    state_q, state_d;
  lsu_req_t      req_q, req_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [31:0]   rd_q, rd_d;
  logic          err_q, err_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;

  logic          in_req;
  logic          tmr_hit;
  logic [1:0]    off;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c;
  logic [31:0]   rd_shift;
  logic [31:0]   ext_word;

  assign in_req   = (state_q == ST_REQ);
  assign off      = req_q.addr[1:0];
  // Down-counter loaded at accept; value 1 marks the last allowed REQ/WAIT cycle.
  // A zero load never reaches 1, which disables the timeout.
  assign tmr_hit  = (tmr_q == TW'(1));
  assign rd_shift = rd_q >> {off, 3'b000};

  lsu_ctrl_ext u_ext (
    .funct3 (req_q.funct3),
    .word   (rd_shift),
    .ext    (ext_word)
  );

  // next-state, request latch, timeout count and bus result capture
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    tmr_d   = tmr_q;
    rd_d    = rd_q;
    err_d   = err_q;
    if ((state_q == ST_REQ || state_q == ST_WAIT) && tmr_q != '0) tmr_d = tmr_q - TW'(1);
    case (state_q)
      ST_IDLE: begin
        if (lsu.core_valid) begin
          req_d.we     = lsu.core_we;
          req_d.funct3 = lsu.core_funct3;
          req_d.addr   = lsu.core_addr;
          req_d.wdata  = lsu.core_wdata;
          tmr_d        = TMR_LOAD;
          rd_d         = '0;
          if (lsu_legal(lsu.core_we, lsu.core_funct3, lsu.core_addr[1:0])) begin
            state_d = ST_REQ;
            err_d   = 1'b0;
          end else begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (tmr_hit) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end else if (lsu.bus_gnt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // a real completion on the last allowed cycle still counts
        if (lsu.bus_rvalid) begin
          state_d = ST_RESP;
          rd_d    = lsu.bus_rdata;
          err_d   = lsu.bus_err;
        end else if (tmr_hit) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // byte enables and lane-replicated store data
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = '0;
    if (req_q.we) begin
      case (req_q.funct3[1:0])
        2'b00: begin
          be_c    = 4'b0001 << off;
          wdata_c = {4{req_q.wdata[7:0]}};
        end
        2'b01: begin
          be_c    = 4'b0011 << off;
          wdata_c = {2{req_q.wdata[15:0]}};
        end
        default: begin
          be_c    = 4'b1111;
          wdata_c = req_q.wdata;
        end
      endcase
    end
  end

  // response values registered as the FSM leaves RESP
  always_comb begin
    rsp_valid_d = (state_q == ST_RESP);
    rsp_err_d   = rsp_valid_d & err_q;
    rsp_rdata_d = (rsp_valid_d && !err_q && !req_q.we) ? ext_word : '0;
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      tmr_q       <= '0;
      rd_q        <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      tmr_q       <= tmr_d;
      rd_q        <= rd_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Bus outputs decode straight from the state flop so reset drops bus_req at once;
  // everything is forced to zero outside REQ.
  assign lsu.core_ready = (state_q == ST_IDLE);
  assign lsu.bus_req    = in_req;
  assign lsu.bus_we     = in_req & req_q.we;
  assign lsu.bus_addr   = in_req ? {req_q.addr[31:2], 2'b00} : '0;
  assign lsu.bus_be     = in_req ? be_c : 4'b0000;
  assign lsu.bus_wdata  = in_req ? wdata_c : '0;
  assign lsu.rsp_valid  = rsp_valid_q;
  assign lsu.rsp_err    = rsp_err_q;
  assign lsu.rsp_rdata  = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl with a transaction-level reference model and per-cycle compare.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  localparam int TO    = 8;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_ctrl_if ifc ();

  lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lsu   (ifc)
  );

  int checks = 0;
  int failures = 0;

  // expected outputs for the current cycle
  bit          chk_en = 1'b0;
  bit          exp_ready, exp_req, exp_we, exp_rsp_valid, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_be;

  // last values seen, for literal checks of directed cases
  logic [31:0] last_addr, last_wdata, last_rdata;
  logic [3:0]  last_be;
  logic        last_we, last_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic bit m_legal(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    if (we && f3 > 2) return 1'b0;
    if (!we && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    return (addr % m_size(f3)) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] w, v;
    w = rd >> (8 * (addr % 4));
    if (m_size(f3) == 1) begin
      v = w % 256;
      if (f3 == 3'd0 && v >= 128) v = v | 32'hFFFF_FF00;
    end else if (m_size(f3) == 2) begin
      v = w % 65536;
      if (f3 == 3'd1 && v >= 32768) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_be(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    sz = m_size(f3);
    if (!we || sz == 4) return 4'hF;
    return 4'(((1 << sz) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (m_size(f3) == 1) return {4{wd[7:0]}};
    if (m_size(f3) == 2) return {2{wd[15:0]}};
    return wd;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("core_ready", ifc.core_ready, exp_ready);
      chk("bus_req", ifc.bus_req, exp_req);
      if (exp_req) begin
        chk("bus_addr", ifc.bus_addr, exp_addr);
        chk("bus_we", ifc.bus_we, exp_we);
        chk("bus_be", ifc.bus_be, exp_be);
        if (exp_we) chk("bus_wdata", ifc.bus_wdata, exp_wdata);
        last_addr  = ifc.bus_addr;
        last_we    = ifc.bus_we;
        last_be    = ifc.bus_be;
        last_wdata = ifc.bus_wdata;
      end
      chk("rsp_valid", ifc.rsp_valid, exp_rsp_valid);
      if (exp_rsp_valid) begin
        chk("rsp_err", ifc.rsp_err, exp_err);
        chk("rsp_rdata", ifc.rsp_rdata, exp_rdata);
        last_rdata = ifc.rsp_rdata;
        last_err   = ifc.rsp_err;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic quiet_inputs();
    ifc.core_valid  = 1'b0;
    ifc.core_we     = 1'b0;
    ifc.core_funct3 = 3'd0;
    ifc.core_addr   = '0;
    ifc.core_wdata  = '0;
    ifc.bus_gnt     = 1'b0;
    ifc.bus_rvalid  = 1'b0;
    ifc.bus_rdata   = '0;
    ifc.bus_err     = 1'b0;
  endtask

  task automatic idle(input int k);
    quiet_inputs();
    exp_ready = 1'b1; exp_req = 1'b0; exp_rsp_valid = 1'b0;
    repeat (k) begin @(posedge clk); #1; end
  endtask

  // One request: grant arrives g cycles into REQ, rvalid r cycles into WAIT.
  // Called #1 after a rising edge; returns #1 after the edge that ends the response cycle.
  task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int g, input int r,
                         input logic [31:0] rd, input bit berr, input bit noise);
    bit legal, tmo;
    int reqlen, m, n, rv_at;
    legal = m_legal(we, f3, addr);
    rv_at = g + 2 + r;
    tmo = 1'b0;
    if (!legal) begin
      reqlen = 0; m = 0;
    end else if (g + 1 >= TO) begin
      reqlen = TO; m = TO; tmo = 1'b1;
    end else begin
      reqlen = g + 1;
      if (g + r + 2 <= TO) m = g + r + 2;
      else begin m = TO; tmo = 1'b1; end
    end
    n = m + 2;
    for (int i = 0; i <= n; i++) begin
      if (i == 0) begin
        ifc.core_valid = 1'b1; ifc.core_we = we; ifc.core_funct3 = f3;
        ifc.core_addr = addr; ifc.core_wdata = wd;
      end else if (i < n && noise) begin
        ifc.core_valid = 1'($urandom_range(0, 1)); ifc.core_we = 1'($urandom_range(0, 1));
        ifc.core_funct3 = 3'($urandom_range(0, 7)); ifc.core_addr = $urandom; ifc.core_wdata = $urandom;
      end else begin
        ifc.core_valid = 1'b0;
      end
      ifc.bus_gnt = legal && (i == g + 1);
      if (legal && i == rv_at) begin
        ifc.bus_rvalid = 1'b1; ifc.bus_rdata = rd; ifc.bus_err = berr;
      end else if (noise && !(legal && i >= g + 2 && i <= rv_at) && $urandom_range(0, 2) == 0) begin
        ifc.bus_rvalid = 1'b1; ifc.bus_rdata = $urandom; ifc.bus_err = 1'($urandom_range(0, 1));
      end else begin
        ifc.bus_rvalid = 1'b0; ifc.bus_rdata = $urandom; ifc.bus_err = 1'($urandom_range(0, 1));
      end
      exp_ready     = (i == 0) || (i == n);
      exp_req       = legal && i >= 1 && i <= reqlen;
      exp_addr      = {addr[31:2], 2'b00};
      exp_we        = we;
      exp_be        = m_be(we, f3, addr);
      exp_wdata     = m_wdata(f3, wd);
      exp_rsp_valid = (i == n);
      exp_err       = !legal || tmo || berr;
      exp_rdata     = (exp_err || we) ? 32'h0 : m_load(f3, addr, rd);
      @(posedge clk); #1;
    end
    quiet_inputs();
    exp_ready = 1'b1; exp_req = 1'b0; exp_rsp_valid = 1'b0;
  endtask

  // Reset asserted mid-transaction (in WAIT, or still in REQ), with a late rvalid.
  task automatic reset_mid(input bit in_wait);
    chk_en = 1'b0;
    quiet_inputs();
    ifc.core_valid = 1'b1; ifc.core_funct3 = 3'd2; ifc.core_addr = 32'h5000;
    @(posedge clk); #1;
    ifc.core_valid = 1'b0;
    ifc.bus_gnt = in_wait;
    @(posedge clk); #1;
    ifc.bus_gnt = 1'b0;
    chk("mid_bus_req", ifc.bus_req, !in_wait);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_bus_req", ifc.bus_req, 1'b0);
    chk("rst_rsp_valid", ifc.rsp_valid, 1'b0);
    ifc.bus_rvalid = 1'b1; ifc.bus_rdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_rsp_valid", ifc.rsp_valid, 1'b0);
    ifc.bus_rvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", ifc.core_ready, 1'b1);
    chk("post_rst_rsp_valid", ifc.rsp_valid, 1'b0);
    exp_ready = 1'b1; exp_req = 1'b0; exp_rsp_valid = 1'b0;
    chk_en = 1'b1;
    idle(3);
  endtask

  initial begin
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          g, r;

    quiet_inputs();
    #12;
    chk("reset_bus_req", ifc.bus_req, 1'b0);
    chk("reset_bus_addr", ifc.bus_addr, 32'h0);
    chk("reset_bus_be", ifc.bus_be, 4'h0);
    chk("reset_bus_we", ifc.bus_we, 1'b0);
    chk("reset_rsp_valid", ifc.rsp_valid, 1'b0);
    chk("reset_rsp_err", ifc.rsp_err, 1'b0);
    chk("reset_rsp_rdata", ifc.rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready", ifc.core_ready, 1'b1);
    exp_ready = 1'b1; exp_req = 1'b0; exp_rsp_valid = 1'b0;
    chk_en = 1'b1;
    idle(2);

    // model pins
    chk("pin_lbu", m_load(3'd4, 32'h1003, 32'h80AA_BBCC), 32'h0000_0080);
    chk("pin_lh", m_load(3'd1, 32'h2002, 32'hF00D_1234), 32'hFFFF_F00D);
    chk("pin_sb_be", m_be(1'b1, 3'd0, 32'h3001), 4'b0010);
    chk("pin_lw_mis", m_legal(1'b0, 3'd2, 32'h4002), 1'b0);

    // LBU upper byte, zero-extended
    run_txn(1'b0, 3'd4, 32'h1003, 32'h0, 0, 0, 32'h80AA_BBCC, 1'b0, 1'b0);
    chk("lbu_be", last_be, 4'b1111);
    chk("lbu_addr", last_addr, 32'h1000);
    chk("lbu_rdata", last_rdata, 32'h0000_0080);
    chk("lbu_err", last_err, 1'b0);
    // LH upper half, sign-extended
    run_txn(1'b0, 3'd1, 32'h2002, 32'h0, 0, 0, 32'hF00D_1234, 1'b0, 1'b0);
    chk("lh_rdata", last_rdata, 32'hFFFF_F00D);
    // SB lane 1
    run_txn(1'b1, 3'd0, 32'h3001, 32'h0000_005A, 1, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("sb_be", last_be, 4'b0010);
    chk("sb_wdata", last_wdata, 32'h5A5A_5A5A);
    chk("sb_we", last_we, 1'b1);
    chk("sb_rdata", last_rdata, 32'h0);
    // misaligned LW and illegal load funct3
    run_txn(1'b0, 3'd2, 32'h4002, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0);
    chk("lw_mis_err", last_err, 1'b1);
    run_txn(1'b0, 3'd3, 32'h4000, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0);
    chk("f3_011_err", last_err, 1'b1);
    // grant held off 3 cycles, then grant never comes
    run_txn(1'b0, 3'd2, 32'h6004, 32'h0, 3, 0, 32'hCAFE_F00D, 1'b0, 1'b0);
    chk("gnt_late_rdata", last_rdata, 32'hCAFE_F00D);
    run_txn(1'b1, 3'd2, 32'h7000, 32'h1111_2222, NEVER, 0, 32'h0, 1'b0, 1'b0);
    chk("timeout_err", last_err, 1'b1);
    // bus error on a load, late rvalid after a WAIT timeout
    run_txn(1'b0, 3'd2, 32'h8000, 32'h0, 0, 1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    chk("bus_err_rdata", last_rdata, 32'h0);
    run_txn(1'b0, 3'd5, 32'h9002, 32'h0, 1, 6, 32'h5555_5555, 1'b0, 1'b1);
    idle(1);

    for (int k = 0; k < 250; k++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we) f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'd5;
      end
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(m_size(f3) - 1);
      if ($urandom_range(0, 9) == 0) g = NEVER;
      else g = $urandom_range(0, 3);
      do r = $urandom_range(0, 6); while (g != NEVER && g + r + 2 == TO);
      run_txn(we, f3, addr, $urandom, g, r, $urandom, ($urandom_range(0, 7) == 0), 1'b1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    reset_mid(1'b1);
    run_txn(1'b0, 3'd0, 32'hA001, 32'h0, 0, 0, 32'h0000_F700, 1'b0, 1'b0);
    chk("post_rst_lb", last_rdata, 32'hFFFF_FFF7);
    reset_mid(1'b0);
    run_txn(1'b1, 3'd1, 32'hB002, 32'h0000_ABCD, 0, 0, 32'h0, 1'b0, 1'b0);
    chk("post_rst_sh_be", last_be, 4'b1100);
    chk("post_rst_sh_wdata", last_wdata, 32'hABCD_ABCD);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
